draining_unit_counter: RTL

BCD down-counter tracking water drained from the irrigation reservoir: each pulse from the drain-flow sensor removes one unit from a loaded volume. It is the complement of the filling unit counter. The filling side counts pulses up from zero. This block is loaded with the current volume and counts down. It flags empty to the irrigation controller and emits an underflow borrow for cascading.

---
 rtl/draining_pkg.sv | 13 +
 rtl/draining_unit_counter_digit.sv | 37 +++
 rtl/draining_unit_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/draining_pkg.sv
// Shared BCD types and helpers for the draining unit counter.
package draining_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    function automatic logic bcd_valid(bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/draining_unit_counter_digit.sv
// One BCD down-counting digit: load, decrement, 0 -> 9 with borrow out.
module bcd_down_digit
    import draining_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  bcd_t load_digit,
    input  logic dec_in,
    output bcd_t digit,
    output logic borrow_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (dec_in) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_in & (digit_q == 4'd0);

endmodule

// File: rtl/draining_unit_counter.sv
// BCD down-counter of drained volume with pulse synchronizer and empty flag.
// Define DRAINING_WRAP_EN to wrap 0 -> all nines instead of saturating.
module draining_unit_counter
    import draining_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pulse,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  empty,
    output logic                  borrow,
    output logic                  load_error
);

    localparam logic [4*DIGITS-1:0] ONE = (4*DIGITS)'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic edge_q, edge_d;
    logic dec_q, dec_d;
    logic empty_q, empty_d;
    logic borrow_q, borrow_d;
    logic load_error_q, load_error_d;

    logic load_valid;
    logic load_ok;
    logic dec_eff;
    logic dec_digits;
    logic zero;
    logic [DIGITS:0] chain;

    always_comb begin
        load_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_value[i*BCD_W +: BCD_W])) begin
                load_valid = 1'b0;
            end
        end
    end

    assign load_ok = load & load_valid;
    assign zero    = (count == '0);
    // A strobe arriving with any load (accepted or not) is dropped.
    assign dec_eff = dec_q & ~load;

`ifdef DRAINING_WRAP_EN
    assign dec_digits = dec_eff;
`else
    assign dec_digits = dec_eff & ~zero;
`endif

    assign chain[0] = dec_digits;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load_ok),
            .load_digit (load_value[g*BCD_W +: BCD_W]),
            .dec_in     (chain[g]),
            .digit      (count[g*BCD_W +: BCD_W]),
            .borrow_out (chain[g+1])
        );
    end

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], pulse};
        edge_d       = sync_q[SYNC_STAGES-1];
        dec_d        = sync_q[SYNC_STAGES-1] & ~edge_q;
        borrow_d     = (dec_eff & zero) | chain[DIGITS];
        load_error_d = load & ~load_valid;
        if (load_ok) begin
            empty_d = (load_value == '0);
        end else if (dec_digits) begin
            empty_d = (count == ONE);
        end else begin
            empty_d = zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= '1;
            edge_q       <= 1'b1;
            dec_q        <= 1'b0;
            empty_q      <= 1'b1;
            borrow_q     <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            dec_q        <= dec_d;
            empty_q      <= empty_d;
            borrow_q     <= borrow_d;
            load_error_q <= load_error_d;
        end
    end

    assign empty      = empty_q;
    assign borrow     = borrow_q;
    assign load_error = load_error_q;

endmodule
